// File: rtl/spartan_audio_pkg.sv
// Shared audio definitions: sample width, frame timing and the stereo sample payload.
package spartan_audio_pkg;

    localparam int unsigned PCM_W      = 16;
    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned POP_SLOT   = 16;
    localparam int unsigned FCNT_W     = $clog2(FRAME_BITS);

    typedef struct packed {
        logic [PCM_W-1:0] left;
        logic [PCM_W-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/pcm_fifo_mem.sv
// Stereo sample storage: synchronous write, asynchronous read, no reset on the array.
module pcm_fifo_mem
    import spartan_audio_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       bit_clock_in,
    input  logic                       write_en,
    input  logic [$clog2(DEPTH)-1:0]   write_ptr,
    input  stereo_sample_t             write_data,
    input  logic [$clog2(DEPTH)-1:0]   read_ptr,
    output stereo_sample_t             read_data
);

    stereo_sample_t storage [DEPTH];

    always_ff @(posedge bit_clock_in) begin
        if (write_en) begin
            storage[write_ptr] <= write_data;
        end
    end

    assign read_data = storage[read_ptr];

endmodule

// File: rtl/pcm_sample_buffer.sv
// Producer-to-serializer stereo FIFO that pops one sample per 32-cycle frame at slot 16.
module pcm_sample_buffer
    import spartan_audio_pkg::*;
#(
    parameter int unsigned DEPTH           = 8,
    parameter bit          UNDERRUN_REPEAT = 1'b0
) (
    input  logic                     bit_clock_in,
    input  logic                     rst_active_high,
    input  logic                     flush,
    input  logic [PCM_W-1:0]         in_left,
    input  logic [PCM_W-1:0]         in_right,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [PCM_W-1:0]         pcm_data_left,
    output logic [PCM_W-1:0]         pcm_data_right,
    output logic                     pcm_data_valid,
    output logic                     frame_tick,
    output logic                     sample_request,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              underrun_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [FCNT_W-1:0] fcnt;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              history;
    logic              full;
    logic              empty;
    logic              pop_slot;
    logic              push;
    logic              pop;
    logic              underrun;
    stereo_sample_t    head;
    stereo_sample_t    wr_sample;

    // Push/pop qualification; flush overrides both and suppresses underrun.
    always_comb begin
        full           = (fifo_level == LVL_W'(DEPTH));
        empty          = (fifo_level == '0);
        pop_slot       = (fcnt == FCNT_W'(POP_SLOT));
        push           = in_valid && !full && !flush;
        pop            = pop_slot && !empty && !flush;
        underrun       = pop_slot && empty && !flush;
        in_ready       = !full;
        sample_request = (fifo_level < LVL_W'(DEPTH / 2));
    end

    assign wr_sample = '{left: in_left, right: in_right};

    pcm_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .bit_clock_in (bit_clock_in),
        .write_en     (push),
        .write_ptr    (wr_ptr),
        .write_data   (wr_sample),
        .read_ptr     (rd_ptr),
        .read_data    (head)
    );

    // Free-running frame position; wraps naturally at 32.
    always_ff @(posedge bit_clock_in or posedge rst_active_high) begin
        if (rst_active_high) begin
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + FCNT_W'(1);
        end
    end

    always_ff @(posedge bit_clock_in or posedge rst_active_high) begin
        if (rst_active_high) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Output hold registers; only a pop slot or flush may change them.
    always_ff @(posedge bit_clock_in or posedge rst_active_high) begin
        if (rst_active_high) begin
            pcm_data_left  <= '0;
            pcm_data_right <= '0;
            pcm_data_valid <= 1'b0;
            history        <= 1'b0;
            frame_tick     <= 1'b0;
        end else begin
            frame_tick <= pop_slot;
            if (flush) begin
                pcm_data_left  <= '0;
                pcm_data_right <= '0;
                pcm_data_valid <= 1'b0;
                history        <= 1'b0;
            end else if (pop) begin
                pcm_data_left  <= head.left;
                pcm_data_right <= head.right;
                pcm_data_valid <= 1'b1;
                history        <= 1'b1;
            end else if (underrun) begin
                if (UNDERRUN_REPEAT && history) begin
                    pcm_data_valid <= 1'b1;
                end else begin
                    pcm_data_left  <= '0;
                    pcm_data_right <= '0;
                    pcm_data_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge bit_clock_in or posedge rst_active_high) begin
        if (rst_active_high) begin
            underrun_count <= '0;
        end else if (underrun && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pcm_sample_buffer.sv
// Directed bench for pcm_sample_buffer; two instances (invalid-on-underrun and repeat) share stimulus.
module tb_pcm_sample_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
    logic        in_valid = 1'b0;

    logic        rdy0, rdy1, val0, val1, tick0, tick1, req0, req1;
    logic [15:0] l0, r0, l1, r1, ur0, ur1;
    logic [3:0]  lvl0, lvl1;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    always #5 clk = ~clk;

    pcm_sample_buffer #(.DEPTH(8), .UNDERRUN_REPEAT(1'b0)) dut0 (
        .bit_clock_in (clk), .rst_active_high (rst), .flush (flush),
        .in_left (in_left), .in_right (in_right), .in_valid (in_valid),
        .in_ready (rdy0), .pcm_data_left (l0), .pcm_data_right (r0),
        .pcm_data_valid (val0), .frame_tick (tick0), .sample_request (req0),
        .fifo_level (lvl0), .underrun_count (ur0)
    );

    pcm_sample_buffer #(.DEPTH(8), .UNDERRUN_REPEAT(1'b1)) dut1 (
        .bit_clock_in (clk), .rst_active_high (rst), .flush (flush),
        .in_left (in_left), .in_right (in_right), .in_valid (in_valid),
        .in_ready (rdy1), .pcm_data_left (l1), .pcm_data_right (r1),
        .pcm_data_valid (val1), .frame_tick (tick1), .sample_request (req1),
        .fifo_level (lvl1), .underrun_count (ur1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        edge_n = 0;
    endtask

    task automatic push_one(input logic [15:0] l, input logic [15:0] r);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        check_eq("rst_level", 32'(lvl0), 32'd0);
        check_eq("rst_valid", 32'(val0), 32'd0);
        check_eq("rst_data", {l0, r0}, 32'h0);
        check_eq("rst_tick", 32'(tick0), 32'd0);
        check_eq("rst_urun", 32'(ur0), 32'd0);
        check_eq("rst_ready", 32'(rdy0), 32'd1);
        check_eq("rst_req", 32'(req0), 32'd1);

        // Fill and drain two samples
        push_one(16'h1111, 16'hAAAA);
        push_one(16'h2222, 16'hBBBB);
        check_eq("fill_level2", 32'(lvl0), 32'd2);
        run_to(16);
        check_eq("pre_slot_valid", 32'(val0), 32'd0);
        check_eq("pre_slot_tick", 32'(tick0), 32'd0);
        tick();
        check_eq("slot17_data", {l0, r0}, 32'h1111AAAA);
        check_eq("slot17_valid", 32'(val0), 32'd1);
        check_eq("slot17_level", 32'(lvl0), 32'd1);
        check_eq("slot17_tick", 32'(tick0), 32'd1);
        tick();
        check_eq("edge18_tick", 32'(tick0), 32'd0);
        check_eq("edge18_hold", {l0, r0}, 32'h1111AAAA);
        run_to(49);
        check_eq("slot49_data", {l0, r0}, 32'h2222BBBB);
        check_eq("slot49_level", 32'(lvl0), 32'd0);
        run_to(81);
        check_eq("ur_norep_valid", 32'(val0), 32'd0);
        check_eq("ur_norep_data", {l0, r0}, 32'h0);
        check_eq("ur_norep_cnt", 32'(ur0), 32'd1);
        check_eq("ur_rep_valid", 32'(val1), 32'd1);
        check_eq("ur_rep_data", {l1, r1}, 32'h2222BBBB);

        // Three underruns from an empty FIFO
        do_reset();
        run_to(81);
        check_eq("ur3_cnt", 32'(ur0), 32'd3);
        check_eq("ur3_valid", 32'(val0), 32'd0);
        check_eq("ur3_data", {l0, r0}, 32'h0);
        check_eq("ur3_rep_nohist_valid", 32'(val1), 32'd0);
        check_eq("ur3_rep_cnt", 32'(ur1), 32'd3);

        // Repeat mode after one sample
        do_reset();
        push_one(16'h7FFF, 16'h8000);
        run_to(17);
        check_eq("rep_first_valid", 32'(val1), 32'd1);
        run_to(49);
        check_eq("rep_hold_data", {l1, r1}, 32'h7FFF8000);
        check_eq("rep_hold_valid", 32'(val1), 32'd1);
        check_eq("rep_hold_cnt", 32'(ur1), 32'd1);
        check_eq("norep_after_data", {l0, r0}, 32'h0);

        // Full FIFO, refused push, push accepted after pop
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            push_one(16'h0100 + 16'(i), 16'h0200 + 16'(i));
            if (i == 3) check_eq("req_level3", 32'(req0), 32'd1);
            if (i == 4) check_eq("req_level4", 32'(req0), 32'd0);
        end
        check_eq("full_level", 32'(lvl0), 32'd8);
        check_eq("full_ready", 32'(rdy0), 32'd0);
        in_left  = 16'h0909;
        in_right = 16'h0A0A;
        in_valid = 1'b1;
        run_to(16);
        check_eq("full_refused", 32'(lvl0), 32'd8);
        tick();
        check_eq("full_pop_level", 32'(lvl0), 32'd7);
        check_eq("full_pop_data", {l0, r0}, 32'h01010201);
        check_eq("full_pop_ready", 32'(rdy0), 32'd1);
        tick();
        in_valid = 1'b0;
        check_eq("full_repush_level", 32'(lvl0), 32'd8);
        run_to(49);
        check_eq("full_second_data", {l0, r0}, 32'h01020202);

        // Push on the pop-slot edge of an empty FIFO
        do_reset();
        run_to(16);
        push_one(16'h3333, 16'hCCCC);
        check_eq("sim_urun", 32'(ur0), 32'd1);
        check_eq("sim_level", 32'(lvl0), 32'd1);
        check_eq("sim_valid", 32'(val0), 32'd0);
        run_to(49);
        check_eq("sim_next_data", {l0, r0}, 32'h3333CCCC);
        check_eq("sim_next_valid", 32'(val0), 32'd1);
        check_eq("sim_next_level", 32'(lvl0), 32'd0);

        // Flush with a simultaneous push
        do_reset();
        for (int i = 1; i <= 6; i++) push_one(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        run_to(17);
        check_eq("pre_flush_level", 32'(lvl0), 32'd5);
        check_eq("pre_flush_valid", 32'(val1), 32'd1);
        run_to(18);
        flush = 1'b1;
        push_one(16'hDEAD, 16'hBEEF);
        flush = 1'b0;
        check_eq("flush_level", 32'(lvl0), 32'd0);
        check_eq("flush_valid", 32'(val0), 32'd0);
        check_eq("flush_data", {l1, r1}, 32'h0);
        check_eq("flush_urun", 32'(ur0), 32'd0);
        run_to(49);
        check_eq("post_flush_urun", 32'(ur0), 32'd1);
        check_eq("post_flush_nohist", 32'(val1), 32'd0);

        // Mid-frame reset at fcnt==9
        do_reset();
        push_one(16'hA5A5, 16'h5A5A);
        push_one(16'h1234, 16'h5678);
        run_to(41);
        check_eq("pre_rst_valid", 32'(val0), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_level", 32'(lvl0), 32'd0);
        check_eq("mid_rst_valid", 32'(val0), 32'd0);
        check_eq("mid_rst_data", {l0, r0}, 32'h0);
        check_eq("mid_rst_ready", 32'(rdy0), 32'd1);
        check_eq("mid_rst_req", 32'(req0), 32'd1);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        edge_n = 0;
        run_to(16);
        check_eq("post_rst_tick16", 32'(tick0), 32'd0);
        tick();
        check_eq("post_rst_tick17", 32'(tick0), 32'd1);
        check_eq("post_rst_discard_urun", 32'(ur0), 32'd1);
        check_eq("post_rst_discard_valid", 32'(val0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
